bf_exec_ctrl: RTL and testbench
===============================

Name: bf_exec_ctrl

Overview:
- Parametrised second-generation Brainfuck execution controller; owns PC, data pointer (DP) and bracket-depth counter.
- Drives program ROM and data RAM directly.
- New versus the first-generation control FSM:
  - proper nested-bracket scan in both directions;
  - valid/ready I/O handshakes;
  - single-step mode;
  - optional data-memory clear on start;
  - error detection with halt.
- Sits between program ROM, data RAM and the I/O front-end (keyboard in, display out).

Parameters:
DATA_W, 8, cell width in bits
PADDR_W, 8, program address width
DADDR_W, 8, data address width
DEPTH_W, 6, bracket-depth counter width
DP_WRAP, 1, 1: DP wraps modulo 2^DADDR_W; 0: DP saturates at 0 and at max
CLEAR_ON_START, 1, 1: zero all data cells before execution begins

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run; ignored while busy
step_en  in  1  1 = single-step mode
step  in  1  one-cycle pulse; releases one instruction in step mode
prog_addr  out  PADDR_W  ROM address; equals PC
prog_rdata  in  4  opcode; synchronous ROM, valid 1 cycle after address
data_addr  out  DADDR_W  RAM address; equals DP, or clear counter in CLEAR
data_rdata  in  DATA_W  synchronous RAM read, 1-cycle latency
data_wdata  out  DATA_W  RAM write data
data_we  out  1  RAM write enable
out_data  out  DATA_W  output byte
out_valid  out  1  output handshake valid
out_ready  in  1  output handshake ready
in_data  in  DATA_W  input byte
in_valid  in  1  input handshake valid
in_ready  out  1  input handshake ready
busy  out  1  run in progress
halted  out  1  stopped on opcode F
err  out  1  stopped on error
err_code  out  2  0 invalid opcode; 1 unmatched '['; 2 unmatched ']'; 3 depth overflow

Behaviour:
- Opcodes: 0 '<', 1 '>', 2 '+', 3 '-', 4 '[', 5 ']', 6 '.', 7 ',', F stop. All others are invalid.
- Reset (async, any state):
  - go to IDLE;
  - PC, DP, depth, clear counter = 0;
  - every output = 0.
- IDLE:
  - start → CLEAR if CLEAR_ON_START, else FETCH;
  - on start: PC = 0, DP = 0, depth = 0, err = 0, halted = 0.
- busy = 1 in every state except IDLE, HALT and ERROR.
- CLEAR:
  - data_we = 1, data_wdata = 0, data_addr = counter;
  - counter counts 0 .. 2^DADDR_W-1, then → FETCH;
  - takes exactly 2^DADDR_W cycles.
- FETCH:
  - presents PC for 1 cycle, then → DECODE;
  - DP is stable, so data_rdata is valid in DECODE, including after a write in the prior DECODE.
- DECODE, per opcode (pc+1 wraps mod 2^PADDR_W; unless noted, pc+1 → FETCH):
  - '<' / '>': DP ∓ 1 (wrap or saturate per DP_WRAP); pc+1. Total 2 cycles.
  - '+' / '-': data_we = 1, data_wdata = data_rdata ± 1 mod 2^DATA_W; pc+1. Total 2 cycles.
  - '[': if data_rdata ≠ 0, pc+1. Else depth = 1, pc+1 → SKF_A.
  - ']': if data_rdata = 0, pc+1. Else depth = 1, pc−1 → SKB_A.
  - '.': out_data = data_rdata, out_valid = 1 → OUT_W.
  - ',': → IN_W.
  - F: → HALT.
  - invalid: → ERROR, code 0.
- Forward scan:
  - SKF_A presents PC (1 cycle) → SKF_C.
  - SKF_C on '[': depth+1. If depth = max before the increment → ERROR, code 3.
  - SKF_C on ']': depth−1. If the result is 0: pc+1 → FETCH.
  - Otherwise, if PC = all-ones → ERROR, code 1; else pc+1 → SKF_A.
- Backward scan, mirror of forward:
  - SKB_C on ']': depth+1.
  - SKB_C on '[': depth−1. If the result is 0: pc+1 (instruction after the matching '[') → FETCH.
  - Otherwise, PC = 0 → ERROR, code 2; else pc−1 → SKB_A.
- OUT_W:
  - out_valid held and out_data stable until out_ready = 1;
  - in that cycle: transfer, out_valid = 0 next cycle, pc+1.
- IN_W:
  - in_ready = 1;
  - on in_valid & in_ready: data_we = 1, data_wdata = in_data, pc+1.
- Step mode:
  - when step_en = 1, each transition into FETCH goes instead to STEP_W;
  - STEP_W waits for a step pulse, then → FETCH;
  - step_en = 0 while in STEP_W → FETCH next cycle.
- HALT: halted = 1. ERROR: err = 1, err_code held.
- From HALT or ERROR, start restarts as from IDLE.
- Simultaneous events: start while busy is ignored. A step pulse outside STEP_W is ignored.

Test Plan:
- CLEAR_ON_START=1, DADDR_W=4; program "+++." then F; out_ready = 1 → 16 clear writes, then out_data = 3 with one out_valid pulse, then halted = 1.
- Program "[+[+]+]-." then F, cell 0 = 0 → both brackets skipped, out_data = 0xFF (0 − 1 wrap).
- Program "++[->+<]>." then F → out_data = 2; check backward scan returns to PC 3.
- ',' with in_valid delayed 5 cycles, then in_data = 0x41; then '.' with out_ready delayed 3 cycles → out_data = 0x41, held stable until ready, no double write.
- Errors:
  - program "[[" followed by all-zero... padding to the ROM end → err = 1, err_code = 1;
  - "+]" at PC 0 → err_code 2;
  - DEPTH_W = 2 with 4 nested '[' → err_code 3;
  - opcode 9 → err_code 0.
- step_en = 1: verify one instruction per step pulse. resetn low during OUT_W → out_valid = 0 immediately; busy = 0.

Source files
------------

// File: rtl/bf_exec_ctrl.sv
// Brainfuck execution controller: owns PC, DP and bracket depth, drives
// program ROM, data RAM and valid/ready byte I/O with step mode and error halt.
module bf_exec_ctrl #(
    parameter int DATA_W         = 8,
    parameter int PADDR_W        = 8,
    parameter int DADDR_W        = 8,
    parameter int DEPTH_W        = 6,
    parameter bit DP_WRAP        = 1'b1,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               step_en,
    input  logic               step,
    output logic [PADDR_W-1:0] prog_addr,
    input  logic [3:0]         prog_rdata,
    output logic [DADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0]  data_rdata,
    output logic [DATA_W-1:0]  data_wdata,
    output logic               data_we,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [1:0]         err_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DECODE,
        S_SKF_A,
        S_SKF_C,
        S_SKB_A,
        S_SKB_C,
        S_OUT_W,
        S_IN_W,
        S_STEP_W,
        S_HALT,
        S_ERROR
    } state_e;

    localparam logic [3:0] OP_LT   = 4'h0;
    localparam logic [3:0] OP_GT   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_JNZ  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_STOP = 4'hF;

    localparam logic [1:0] E_OPC   = 2'd0;
    localparam logic [1:0] E_UNM_L = 2'd1;
    localparam logic [1:0] E_UNM_R = 2'd2;
    localparam logic [1:0] E_DEPTH = 2'd3;

    state_e               state_q, state_d;
    logic [PADDR_W-1:0]   pc_q, pc_d;
    logic [DADDR_W-1:0]   dp_q, dp_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [DADDR_W-1:0]   clr_q, clr_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [1:0]           err_code_q, err_code_d;

    logic [PADDR_W-1:0]   pc_inc, pc_dec;
    logic [DADDR_W-1:0]   dp_inc, dp_dec;
    logic                 depth_max;
    logic                 scan_go;
    state_e               fetch_st;

    assign pc_inc    = pc_q + PADDR_W'(1);
    assign pc_dec    = pc_q - PADDR_W'(1);
    assign depth_max = (depth_q == '1);

    // Saturating mode pins DP at either end instead of wrapping.
    assign dp_inc = (dp_q == '1) ? (DP_WRAP ? '0 : '1) : dp_q + DADDR_W'(1);
    assign dp_dec = (dp_q == '0) ? (DP_WRAP ? '1 : '0) : dp_q - DADDR_W'(1);

    assign fetch_st = step_en ? S_STEP_W : S_FETCH;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dp_d       = dp_q;
        depth_d    = depth_q;
        clr_d      = clr_q;
        out_data_d = out_data_q;
        err_code_d = err_code_q;
        data_addr  = dp_q;
        data_wdata = '0;
        data_we    = 1'b0;
        scan_go    = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    pc_d       = '0;
                    dp_d       = '0;
                    depth_d    = '0;
                    clr_d      = '0;
                    err_code_d = E_OPC;
                    state_d    = CLEAR_ON_START ? S_CLEAR : fetch_st;
                end
            end
            S_CLEAR: begin
                data_we   = 1'b1;
                data_addr = clr_q;
                clr_d     = clr_q + DADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = fetch_st;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (prog_rdata)
                    OP_LT: begin
                        dp_d    = dp_dec;
                        pc_d    = pc_inc;
                        state_d = fetch_st;
                    end
                    OP_GT: begin
                        dp_d    = dp_inc;
                        pc_d    = pc_inc;
                        state_d = fetch_st;
                    end
                    OP_INC: begin
                        data_we    = 1'b1;
                        data_wdata = data_rdata + DATA_W'(1);
                        pc_d       = pc_inc;
                        state_d    = fetch_st;
                    end
                    OP_DEC: begin
                        data_we    = 1'b1;
                        data_wdata = data_rdata - DATA_W'(1);
                        pc_d       = pc_inc;
                        state_d    = fetch_st;
                    end
                    OP_JZ: begin
                        pc_d = pc_inc;
                        if (data_rdata != '0) begin
                            state_d = fetch_st;
                        end else begin
                            depth_d = DEPTH_W'(1);
                            state_d = S_SKF_A;
                        end
                    end
                    OP_JNZ: begin
                        if (data_rdata == '0) begin
                            pc_d    = pc_inc;
                            state_d = fetch_st;
                        end else begin
                            depth_d = DEPTH_W'(1);
                            pc_d    = pc_dec;
                            state_d = S_SKB_A;
                        end
                    end
                    OP_OUT: begin
                        out_data_d = data_rdata;
                        state_d    = S_OUT_W;
                    end
                    OP_IN: begin
                        state_d = S_IN_W;
                    end
                    OP_STOP: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        err_code_d = E_OPC;
                        state_d    = S_ERROR;
                    end
                endcase
            end
            S_SKF_A: begin
                state_d = S_SKF_C;
            end
            S_SKF_C: begin
                scan_go = 1'b1;
                if (prog_rdata == OP_JZ) begin
                    if (depth_max) begin
                        scan_go    = 1'b0;
                        err_code_d = E_DEPTH;
                        state_d    = S_ERROR;
                    end else begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end else if (prog_rdata == OP_JNZ) begin
                    depth_d = depth_q - DEPTH_W'(1);
                    if (depth_q == DEPTH_W'(1)) begin
                        scan_go = 1'b0;
                        pc_d    = pc_inc;
                        state_d = fetch_st;
                    end
                end
                if (scan_go) begin
                    if (pc_q == '1) begin
                        err_code_d = E_UNM_L;
                        state_d    = S_ERROR;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_SKF_A;
                    end
                end
            end
            S_SKB_A: begin
                state_d = S_SKB_C;
            end
            S_SKB_C: begin
                scan_go = 1'b1;
                if (prog_rdata == OP_JNZ) begin
                    if (depth_max) begin
                        scan_go    = 1'b0;
                        err_code_d = E_DEPTH;
                        state_d    = S_ERROR;
                    end else begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end else if (prog_rdata == OP_JZ) begin
                    depth_d = depth_q - DEPTH_W'(1);
                    if (depth_q == DEPTH_W'(1)) begin
                        // Resume just past the matching '['.
                        scan_go = 1'b0;
                        pc_d    = pc_inc;
                        state_d = fetch_st;
                    end
                end
                if (scan_go) begin
                    if (pc_q == '0) begin
                        err_code_d = E_UNM_R;
                        state_d    = S_ERROR;
                    end else begin
                        pc_d    = pc_dec;
                        state_d = S_SKB_A;
                    end
                end
            end
            S_OUT_W: begin
                if (out_ready) begin
                    pc_d    = pc_inc;
                    state_d = fetch_st;
                end
            end
            S_IN_W: begin
                if (in_valid) begin
                    data_we    = 1'b1;
                    data_wdata = in_data;
                    pc_d       = pc_inc;
                    state_d    = fetch_st;
                end
            end
            S_STEP_W: begin
                if (step || !step_en) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            dp_q       <= '0;
            depth_q    <= '0;
            clr_q      <= '0;
            out_data_q <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dp_q       <= dp_d;
            depth_q    <= depth_d;
            clr_q      <= clr_d;
            out_data_q <= out_data_d;
            err_code_q <= err_code_d;
        end
    end

    assign prog_addr = pc_q;
    assign out_data  = out_data_q;
    assign err_code  = err_code_q;
    assign out_valid = (state_q == S_OUT_W);
    assign in_ready  = (state_q == S_IN_W);
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERROR);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT) &&
                       (state_q != S_ERROR);

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Testbench for bf_exec_ctrl: directed vectors, corner sequences and
// random programs checked against a small Brainfuck interpreter.
module tb_bf_exec_ctrl;

    localparam int DW     = 8;
    localparam int PW     = 8;
    localparam int AW     = 4;
    localparam int DEPTHW = 2;
    localparam int MAXD   = (1 << DEPTHW) - 1;

    logic          clk = 1'b0;
    logic          resetn, start, step_en, step;
    logic [PW-1:0] prog_addr;
    logic [3:0]    prog_rdata;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_rdata, data_wdata;
    logic          data_we;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic          busy, halted, err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    bf_exec_ctrl #(
        .DATA_W(DW), .PADDR_W(PW), .DADDR_W(AW), .DEPTH_W(DEPTHW),
        .DP_WRAP(1'b1), .CLEAR_ON_START(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .step_en(step_en),
        .step(step), .prog_addr(prog_addr), .prog_rdata(prog_rdata),
        .data_addr(data_addr), .data_rdata(data_rdata),
        .data_wdata(data_wdata), .data_we(data_we),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .halted(halted), .err(err), .err_code(err_code)
    );

    logic [3:0]    rom [256];
    logic [DW-1:0] ram [16];

    always @(posedge clk) begin
        prog_rdata <= rom[prog_addr];
        if (data_we) ram[data_addr] <= data_wdata;
        data_rdata <= ram[data_addr];
    end

    logic          auto_io;
    logic          man_ready, man_valid;
    logic [DW-1:0] man_data;
    logic          rnd_ready, rnd_valid;
    int            in_idx;
    logic [DW-1:0] in_bytes [64];

    assign out_ready = auto_io ? rnd_ready : man_ready;
    assign in_valid  = auto_io ? rnd_valid : man_valid;
    assign in_data   = auto_io ? in_bytes[in_idx[5:0]] : man_data;

    initial begin
        bit xfer;
        rnd_ready = 1'b0;
        rnd_valid = 1'b0;
        in_idx    = 0;
        forever begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (auto_io && xfer) in_idx++;
            rnd_ready = ($urandom_range(3) != 0);
            rnd_valid = ($urandom_range(2) != 0);
        end
    end

    logic [DW-1:0] out_q [$];
    logic [PW-1:0] pc_tr [$];
    int            wr_cnt = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (data_we) wr_cnt <= wr_cnt + 1;
        if (pc_tr.size() == 0 || pc_tr[$] != prog_addr)
            pc_tr.push_back(prog_addr);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] enc(input byte c);
        case (c)
            "<": return 4'h0;
            ">": return 4'h1;
            "+": return 4'h2;
            "-": return 4'h3;
            "[": return 4'h4;
            "]": return 4'h5;
            ".": return 4'h6;
            ",": return 4'h7;
            "9": return 4'h9;
            "F": return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    task automatic load(input string s);
        for (int i = 0; i < 256; i++) rom[i] = 4'h0;
        for (int i = 0; i < s.len(); i++) rom[i] = enc(s[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (halted || err) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Reference interpreter over the loaded ROM and 16 cleared cells.
    logic [DW-1:0] m_mem [16];
    logic [DW-1:0] m_out [$];
    bit            m_err, m_ok;
    logic [1:0]    m_code;

    task automatic model_run(input int in_base);
        int pc, dp, k, n, d, p;
        logic [3:0] op;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_out.delete();
        m_err = 0; m_ok = 0; m_code = 2'd0;
        pc = 0; dp = 0; k = in_base; n = 0;
        while (n < 300) begin
            n++;
            op = rom[pc];
            case (op)
                4'h0: begin dp = (dp + 15) % 16; pc = (pc + 1) % 256; end
                4'h1: begin dp = (dp + 1) % 16; pc = (pc + 1) % 256; end
                4'h2: begin m_mem[dp] = m_mem[dp] + 8'd1; pc = (pc + 1) % 256; end
                4'h3: begin m_mem[dp] = m_mem[dp] - 8'd1; pc = (pc + 1) % 256; end
                4'h4: begin
                    if (m_mem[dp] != 0) pc = (pc + 1) % 256;
                    else begin
                        d = 1;
                        p = (pc + 1) % 256;
                        forever begin
                            if (rom[p] == 4'h4) begin
                                if (d == MAXD) begin
                                    m_err = 1; m_code = 2'd3; m_ok = 1; return;
                                end
                                d++;
                            end else if (rom[p] == 4'h5) begin
                                d--;
                                if (d == 0) begin pc = (p + 1) % 256; break; end
                            end
                            if (p == 255) begin
                                m_err = 1; m_code = 2'd1; m_ok = 1; return;
                            end
                            p++;
                        end
                    end
                end
                4'h5: begin
                    if (m_mem[dp] == 0) pc = (pc + 1) % 256;
                    else begin
                        d = 1;
                        p = (pc + 255) % 256;
                        forever begin
                            if (rom[p] == 4'h5) begin
                                if (d == MAXD) begin
                                    m_err = 1; m_code = 2'd3; m_ok = 1; return;
                                end
                                d++;
                            end else if (rom[p] == 4'h4) begin
                                d--;
                                if (d == 0) begin pc = (p + 1) % 256; break; end
                            end
                            if (p == 0) begin
                                m_err = 1; m_code = 2'd2; m_ok = 1; return;
                            end
                            p--;
                        end
                    end
                end
                4'h6: begin m_out.push_back(m_mem[dp]); pc = (pc + 1) % 256; end
                4'h7: begin
                    m_mem[dp] = in_bytes[k % 64];
                    k++;
                    pc = (pc + 1) % 256;
                end
                4'hF: begin m_ok = 1; return; end
                default: begin m_err = 1; m_code = 2'd0; m_ok = 1; return; end
            endcase
        end
    endtask

    typedef struct {
        string      prog;
        int         n_out;
        logic [7:0] o0;
        logic [7:0] o1;
        bit         e_halt;
        bit         e_err;
        logic [1:0] code;
    } vec_t;

    vec_t vt [9];

    initial begin
        bit ok;
        int bo, w0, bad, idx;
        logic [47:0] tr;

        vt[0] = '{"+++.F",       1, 8'h03, 8'h00, 1, 0, 2'd0};
        vt[1] = '{"[+[+]+]-.F",  1, 8'hFF, 8'h00, 1, 0, 2'd0};
        vt[2] = '{"++[->+<]>.F", 1, 8'h02, 8'h00, 1, 0, 2'd0};
        vt[3] = '{"[[",          0, 8'h00, 8'h00, 0, 1, 2'd1};
        vt[4] = '{"+]",          0, 8'h00, 8'h00, 0, 1, 2'd2};
        vt[5] = '{"[[[[F",       0, 8'h00, 8'h00, 0, 1, 2'd3};
        vt[6] = '{"9",           0, 8'h00, 8'h00, 0, 1, 2'd0};
        vt[7] = '{"<-.>++.F",    2, 8'hFF, 8'h02, 1, 0, 2'd0};
        vt[8] = '{"-[-].F",      1, 8'h00, 8'h00, 1, 0, 2'd0};

        for (int i = 0; i < 64; i++) in_bytes[i] = DW'($urandom);
        resetn = 1'b1; start = 1'b0; step = 1'b0; step_en = 1'b0;
        auto_io = 1'b0; man_ready = 1'b0; man_valid = 1'b0; man_data = '0;
        load("+++.F");
        #2 resetn = 1'b0;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data_we", data_we, 0);
        chk("rst_addrs", {prog_addr, data_addr}, 0);
        chk("rst_out_data", out_data, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Clear phase: 16 zero writes at ascending addresses, then run.
        man_ready = 1'b1;
        bo = out_q.size();
        pulse_start();
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (!(data_we && data_wdata == 0 && data_addr == AW'(k) && busy))
                bad++;
            tick();
        end
        chk("clear_seq", bad, 0);
        chk("clear_len", data_we, 0);
        wait_done(500, ok);
        chk("clear_run_done", ok, 1);
        chk("clear_run_halt", halted, 1);
        chk("clear_run_nout", out_q.size() - bo, 1);
        if (out_q.size() > bo) chk("clear_run_out", out_q[bo], 3);

        foreach (vt[i]) begin
            load(vt[i].prog);
            bo = out_q.size();
            pulse_start();
            wait_done(6000, ok);
            chk($sformatf("v%0d_done", i), ok, 1);
            chk($sformatf("v%0d_halt", i), halted, vt[i].e_halt);
            chk($sformatf("v%0d_err", i), err, vt[i].e_err);
            if (vt[i].e_err) chk($sformatf("v%0d_code", i), err_code, vt[i].code);
            chk($sformatf("v%0d_nout", i), out_q.size() - bo, vt[i].n_out);
            if (vt[i].n_out > 0 && out_q.size() > bo)
                chk($sformatf("v%0d_o0", i), out_q[bo], vt[i].o0);
            if (vt[i].n_out > 1 && out_q.size() > bo + 1)
                chk($sformatf("v%0d_o1", i), out_q[bo + 1], vt[i].o1);
        end

        // Backward scan path after the ']' at PC 7.
        load("++[->+<]>.F");
        bo = pc_tr.size();
        pulse_start();
        wait_done(1000, ok);
        chk("bscan_done", ok, 1);
        idx = -1;
        for (int i = bo; i < pc_tr.size(); i++)
            if (pc_tr[i] == 8'd7) begin idx = i; break; end
        tr = '0;
        if (idx >= 0 && idx + 6 < pc_tr.size())
            for (int j = 1; j <= 6; j++) tr = {tr[39:0], pc_tr[idx + j]};
        chk("bscan_trace", tr, {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd3});

        // Delayed input then stalled output.
        load(",.F");
        man_ready = 1'b0;
        bo = out_q.size();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) ok = 1; else tick();
        end
        chk("io_in_ready", ok, 1);
        w0 = wr_cnt;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!in_ready || data_we) bad++;
            tick();
        end
        chk("io_in_wait", bad, 0);
        man_valid = 1'b1;
        man_data = 8'h41;
        tick();
        man_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_valid) ok = 1; else tick();
        end
        chk("io_out_valid", ok, 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (!out_valid || out_data != 8'h41) bad++;
            tick();
        end
        chk("io_out_hold", bad, 0);
        man_ready = 1'b1;
        tick();
        chk("io_out_drop", out_valid, 0);
        wait_done(100, ok);
        chk("io_done", halted, 1);
        chk("io_writes", wr_cnt - w0, 1);
        chk("io_nout", out_q.size() - bo, 1);
        if (out_q.size() > bo) chk("io_out", out_q[bo], 8'h41);
        chk("io_cell", ram[0], 8'h41);

        // Single step: one instruction per pulse.
        load("+++.F");
        step_en = 1'b1;
        bo = out_q.size();
        pulse_start();
        tick(20);
        chk("step_hold", {busy, prog_addr, ram[0]}, {1'b1, 8'd0, 8'd0});
        for (int k = 1; k <= 4; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick(6);
            chk($sformatf("step%0d_pc", k), prog_addr, k);
            chk($sformatf("step%0d_cell", k), ram[0], k < 4 ? k : 3);
        end
        chk("step_nout", out_q.size() - bo, 1);
        step_en = 1'b0;
        wait_done(50, ok);
        chk("step_halt", halted, 1);

        // Reset while an output is pending.
        load(".F");
        man_ready = 1'b0;
        pulse_start();
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_valid) ok = 1; else tick();
        end
        chk("rstow_reach", ok, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rstow_out_valid", out_valid, 0);
        chk("rstow_busy", busy, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Random programs against the interpreter.
        auto_io = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int len, tries, ib;
            tries = 0;
            do begin
                len = $urandom_range(3, 12);
                for (int i = 0; i < 256; i++) rom[i] = 4'h0;
                for (int i = 0; i < len; i++) begin
                    rom[i] = 4'($urandom_range(0, 7));
                    if ($urandom_range(40) == 0) rom[i] = 4'hA;
                end
                rom[len] = 4'hF;
                ib = in_idx;
                model_run(ib);
                tries++;
            end while (!m_ok && tries < 50);
            bo = out_q.size();
            pulse_start();
            wait_done(20000, ok);
            chk($sformatf("r%0d_done", r), ok, 1);
            chk($sformatf("r%0d_state", r), {halted, err}, {!m_err, m_err});
            if (m_err) chk($sformatf("r%0d_code", r), err_code, m_code);
            chk($sformatf("r%0d_nout", r), out_q.size() - bo, m_out.size());
            bad = 0;
            for (int i = 0; i < m_out.size(); i++)
                if (bo + i >= out_q.size() || out_q[bo + i] != m_out[i]) bad++;
            chk($sformatf("r%0d_outs", r), bad, 0);
            bad = 0;
            for (int i = 0; i < 16; i++) if (ram[i] != m_mem[i]) bad++;
            chk($sformatf("r%0d_mem", r), bad, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
